// File: rtl/id_decode_buffer.sv
// WAY-wide decode stage feeding a circular buffer of decoded uops.
// Surviving lanes are compacted in program order; dispatch drains 0..WAY oldest uops per cycle.
package id_decode_pkg;
    localparam int BR_INDEX_W = 16;

    localparam logic [3:0] FU_ALU    = 4'd0;
    localparam logic [3:0] FU_BRANCH = 4'd1;
    localparam logic [3:0] FU_MEM_LD = 4'd2;
    localparam logic [3:0] FU_MEM_ST = 4'd3;
    localparam logic [3:0] FU_MUL    = 4'd4;
    localparam logic [3:0] FU_DIV    = 4'd5;
    localparam logic [3:0] FU_LUI_B  = 4'd8;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef struct packed {
        logic                  id_valid;
        logic [6:0]            opcode;
        logic [31:0]           pc;
        logic [31:0]           pc_next;
        logic [4:0]            rd;
        logic [4:0]            rs1_s;
        logic [4:0]            rs2_s;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [31:0]           imms;
        logic [3:0]            fu_idx;
        logic                  rd_valid;
        logic                  rs1_s_valid;
        logic                  rs2_s_valid;
        logic                  jump_valid;
        logic                  br_valid;
        logic                  mem_stage_valid;
        logic                  imm_flag;
        logic                  br_pred_valid;
        logic                  br_pred_taken;
        logic [31:0]           br_pred_target;
        logic [BR_INDEX_W-1:0] br_pred_index;
    } id_rename_nd_dispatch_t;
endpackage

module id_decode_buffer
    import id_decode_pkg::*;
#(
    parameter int WAY          = 2,
    parameter int DEPTH        = 8,
    parameter int HISTORY_BITS = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                iq_empty,
    output logic                                iq_pop,
    input  logic                                iq_resp,
    input  logic [WAY-1:0][31:0]                iq_rdata,
    input  logic [WAY-1:0]                      iq_lane_valid,
    input  logic [WAY-1:0][31:0]                pc,
    input  logic [WAY-1:0][31:0]                pc_next,
    input  logic [WAY-1:0]                      br_pred_valid,
    input  logic [WAY-1:0]                      br_pred_taken,
    input  logic [WAY-1:0][31:0]                br_pred_target,
    input  logic [WAY-1:0][HISTORY_BITS-1:0]    br_pred_index,
    output id_rename_nd_dispatch_t [WAY-1:0]    uop_out,
    output logic [WAY-1:0]                      uop_valid,
    input  logic [$clog2(WAY+1)-1:0]            disp_count,
    output logic [$clog2(DEPTH+1)-1:0]          occupancy,
    output logic                                illegal_seen
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int CNT_W = $clog2(WAY+1);

    id_rename_nd_dispatch_t entries_q [DEPTH];
    id_rename_nd_dispatch_t entries_d [DEPTH];
    id_rename_nd_dispatch_t dec [WAY];
    logic [WAY-1:0]   lane_ok;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;
    logic             illegal_seen_q, illegal_seen_d;
    logic [CNT_W-1:0] kept;
    logic             wr_en;

    // Handshake: iq_pop requests a bundle this cycle; iq_resp qualifies same-cycle data, no write without it.
    assign iq_pop = !iq_empty && (occupancy_q <= OCC_W'(DEPTH - WAY)) && !flush && !rst;
    assign wr_en  = iq_pop && iq_resp;

    always_comb begin
        for (int i = 0; i < WAY; i++) begin
            dec[i]                = '0;
            lane_ok[i]            = 1'b1;
            dec[i].id_valid       = 1'b1;
            dec[i].opcode         = iq_rdata[i][6:0];
            dec[i].pc             = pc[i];
            dec[i].pc_next        = pc_next[i];
            dec[i].rd             = iq_rdata[i][11:7];
            dec[i].rs1_s          = iq_rdata[i][19:15];
            dec[i].funct3         = iq_rdata[i][14:12];
            dec[i].br_pred_valid  = br_pred_valid[i];
            dec[i].br_pred_taken  = br_pred_taken[i];
            dec[i].br_pred_target = br_pred_target[i];
            dec[i].br_pred_index  = BR_INDEX_W'(br_pred_index[i]);
            case (iq_rdata[i][6:0])
                OP_LUI, OP_AUIPC: begin
                    dec[i].imms     = {iq_rdata[i][31:12], 12'b0};
                    dec[i].fu_idx   = (iq_rdata[i][6:0] == OP_LUI) ? FU_LUI_B : FU_ALU;
                    dec[i].rd_valid = 1'b1;
                    dec[i].imm_flag = 1'b1;
                end
                OP_JAL: begin
                    dec[i].imms       = {{12{iq_rdata[i][31]}}, iq_rdata[i][19:12], iq_rdata[i][20],
                                         iq_rdata[i][30:21], 1'b0};
                    dec[i].fu_idx     = FU_BRANCH;
                    dec[i].rd_valid   = 1'b1;
                    dec[i].jump_valid = 1'b1;
                    dec[i].imm_flag   = 1'b1;
                end
                OP_JALR, OP_LOAD, OP_IMM: begin
                    dec[i].imms        = {{20{iq_rdata[i][31]}}, iq_rdata[i][31:20]};
                    dec[i].rd_valid    = 1'b1;
                    dec[i].rs1_s_valid = 1'b1;
                    dec[i].imm_flag    = 1'b1;
                    if (iq_rdata[i][6:0] == OP_JALR) begin
                        dec[i].fu_idx     = FU_BRANCH;
                        dec[i].jump_valid = 1'b1;
                    end else if (iq_rdata[i][6:0] == OP_LOAD) begin
                        dec[i].fu_idx          = FU_MEM_LD;
                        dec[i].mem_stage_valid = 1'b1;
                    end else begin
                        dec[i].fu_idx = FU_ALU;
                        // Shift-right immediates carry the arithmetic/logical select in funct7.
                        if (iq_rdata[i][14:12] == 3'd5) dec[i].funct7 = iq_rdata[i][31:25];
                    end
                end
                OP_BR: begin
                    dec[i].imms        = {{20{iq_rdata[i][31]}}, iq_rdata[i][7], iq_rdata[i][30:25],
                                          iq_rdata[i][11:8], 1'b0};
                    dec[i].fu_idx      = FU_BRANCH;
                    dec[i].rs1_s_valid = 1'b1;
                    dec[i].rs2_s_valid = 1'b1;
                    dec[i].rs2_s       = iq_rdata[i][24:20];
                    dec[i].br_valid    = 1'b1;
                    dec[i].imm_flag    = 1'b1;
                end
                OP_STORE: begin
                    dec[i].imms            = {{20{iq_rdata[i][31]}}, iq_rdata[i][31:25], iq_rdata[i][11:7]};
                    dec[i].fu_idx          = FU_MEM_ST;
                    dec[i].rs1_s_valid     = 1'b1;
                    dec[i].rs2_s_valid     = 1'b1;
                    dec[i].rs2_s           = iq_rdata[i][24:20];
                    dec[i].mem_stage_valid = 1'b1;
                    dec[i].imm_flag        = 1'b1;
                end
                OP_REG: begin
                    dec[i].rd_valid    = 1'b1;
                    dec[i].rs1_s_valid = 1'b1;
                    dec[i].rs2_s_valid = 1'b1;
                    dec[i].rs2_s       = iq_rdata[i][24:20];
                    dec[i].funct7      = iq_rdata[i][31:25];
                    if (iq_rdata[i][25]) dec[i].fu_idx = iq_rdata[i][14] ? FU_DIV : FU_MUL;
                    else                 dec[i].fu_idx = FU_ALU;
                end
                default: lane_ok[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        entries_d      = entries_q;
        illegal_seen_d = illegal_seen_q;
        kept           = '0;
        for (int i = 0; i < WAY; i++) begin
            if (wr_en && iq_lane_valid[i]) begin
                if (lane_ok[i]) begin
                    entries_d[tail_q + PTR_W'(kept)] = dec[i];
                    kept = kept + 1'b1;
                end else begin
                    illegal_seen_d = 1'b1;
                end
            end
        end
        head_d      = head_q + PTR_W'(disp_count);
        tail_d      = tail_q + PTR_W'(kept);
        occupancy_d = occupancy_q + OCC_W'(kept) - OCC_W'(disp_count);
        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            occupancy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            occupancy_q    <= '0;
            illegal_seen_q <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            occupancy_q    <= occupancy_d;
            illegal_seen_q <= illegal_seen_d;
        end
        entries_q <= entries_d;
    end

    // LUI has no fixed unit; its port follows the output slot it lands in.
    always_comb begin
        for (int s = 0; s < WAY; s++) begin
            uop_out[s]   = '0;
            uop_valid[s] = (OCC_W'(s) < occupancy_q);
            if (uop_valid[s]) begin
                uop_out[s] = entries_q[head_q + PTR_W'(s)];
                if (uop_out[s].fu_idx == FU_LUI_B) uop_out[s].fu_idx = FU_LUI_B + 4'(s);
            end
        end
    end

    assign occupancy    = occupancy_q;
    assign illegal_seen = illegal_seen_q;

    assert property (@(posedge clk) disable iff (rst || flush) 32'(disp_count) <= $countones(uop_valid));
endmodule

// File: tb/tb_id_decode_buffer.sv
// Bench for id_decode_buffer: directed scenarios plus randomized traffic checked
// against a queue-based model that decodes straight from the instruction-set rules.
module tb_id_decode_buffer;
    import id_decode_pkg::*;

    localparam int WAY   = 2;
    localparam int DEPTH = 8;
    localparam int HB    = 8;
    localparam int CNT_W = $clog2(WAY+1);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic                             clk;
    logic                             rst;
    logic                             flush;
    logic                             iq_empty;
    logic                             iq_pop;
    logic                             iq_resp;
    logic [WAY-1:0][31:0]             iq_rdata;
    logic [WAY-1:0]                   iq_lane_valid;
    logic [WAY-1:0][31:0]             pc;
    logic [WAY-1:0][31:0]             pc_next;
    logic [WAY-1:0]                   br_pred_valid;
    logic [WAY-1:0]                   br_pred_taken;
    logic [WAY-1:0][31:0]             br_pred_target;
    logic [WAY-1:0][HB-1:0]           br_pred_index;
    id_rename_nd_dispatch_t [WAY-1:0] uop_out;
    logic [WAY-1:0]                   uop_valid;
    logic [CNT_W-1:0]                 disp_count;
    logic [OCC_W-1:0]                 occupancy;
    logic                             illegal_seen;

    int n_vec = 0;
    int n_err = 0;
    id_rename_nd_dispatch_t exp_q[$];
    logic exp_ill;
    logic exp_pop;
    logic obs_pop;
    logic [6:0] op_tab [10];

    id_decode_buffer #(.WAY(WAY), .DEPTH(DEPTH), .HISTORY_BITS(HB)) dut (
        .clk(clk), .rst(rst), .flush(flush), .iq_empty(iq_empty), .iq_pop(iq_pop),
        .iq_resp(iq_resp), .iq_rdata(iq_rdata), .iq_lane_valid(iq_lane_valid),
        .pc(pc), .pc_next(pc_next), .br_pred_valid(br_pred_valid),
        .br_pred_taken(br_pred_taken), .br_pred_target(br_pred_target),
        .br_pred_index(br_pred_index), .uop_out(uop_out), .uop_valid(uop_valid),
        .disp_count(disp_count), .occupancy(occupancy), .illegal_seen(illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] addi_k(input int k);
        return (32'(k) << 20) | 32'h0000_0093;
    endfunction

    // Reference decode from the instruction-set definition, using the current lane side inputs.
    function automatic id_rename_nd_dispatch_t ref_decode(input logic [31:0] ins, input int lane,
                                                          output logic legal);
        id_rename_nd_dispatch_t u;
        logic [6:0] op;
        logic [2:0] f3;
        logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_imm, is_reg;
        op = ins[6:0];
        f3 = ins[14:12];
        is_lui   = (op == 7'h37);
        is_auipc = (op == 7'h17);
        is_jal   = (op == 7'h6F);
        is_jalr  = (op == 7'h67);
        is_br    = (op == 7'h63);
        is_load  = (op == 7'h03);
        is_store = (op == 7'h23);
        is_imm   = (op == 7'h13);
        is_reg   = (op == 7'h33);
        legal = is_lui | is_auipc | is_jal | is_jalr | is_br | is_load | is_store | is_imm | is_reg;
        u = '0;
        u.id_valid        = 1'b1;
        u.opcode          = op;
        u.pc              = pc[lane];
        u.pc_next         = pc_next[lane];
        u.br_pred_valid   = br_pred_valid[lane];
        u.br_pred_taken   = br_pred_taken[lane];
        u.br_pred_target  = br_pred_target[lane];
        u.br_pred_index   = BR_INDEX_W'(br_pred_index[lane]);
        u.rd              = ins[11:7];
        u.rs1_s           = ins[19:15];
        u.funct3          = f3;
        u.rs2_s_valid     = is_br | is_store | is_reg;
        u.rs2_s           = u.rs2_s_valid ? ins[24:20] : 5'd0;
        u.rs1_s_valid     = !(is_lui | is_auipc | is_jal);
        u.rd_valid        = !(is_br | is_store);
        u.jump_valid      = is_jal | is_jalr;
        u.br_valid        = is_br;
        u.mem_stage_valid = is_load | is_store;
        u.imm_flag        = !is_reg;
        u.funct7          = (is_reg || (is_imm && f3 == 3'd5)) ? ins[31:25] : 7'd0;
        if (is_store)               u.imms = 32'($signed({ins[31:25], ins[11:7]}));
        else if (is_br)             u.imms = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        else if (is_lui | is_auipc) u.imms = ins & 32'hFFFF_F000;
        else if (is_jal)            u.imms = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        else if (is_reg)            u.imms = 32'd0;
        else                        u.imms = 32'($signed(ins[31:20]));
        if (is_lui)                          u.fu_idx = FU_LUI_B;
        else if (is_jal | is_jalr | is_br)   u.fu_idx = FU_BRANCH;
        else if (is_load)                    u.fu_idx = FU_MEM_LD;
        else if (is_store)                   u.fu_idx = FU_MEM_ST;
        else if (is_reg && ins[25])          u.fu_idx = f3[2] ? FU_DIV : FU_MUL;
        else                                 u.fu_idx = FU_ALU;
        return u;
    endfunction

    // Driver: applies one cycle of inputs, records iq_pop before the edge and advances the model.
    task automatic drive(input logic fl, input logic emp, input logic resp, input logic [WAY-1:0] lv,
                         input logic [WAY-1:0][31:0] ins, input int disp);
        id_rename_nd_dispatch_t u;
        logic legal;
        rst           = 1'b0;
        flush         = fl;
        iq_empty      = emp;
        iq_resp       = resp;
        iq_lane_valid = lv;
        iq_rdata      = ins;
        disp_count    = CNT_W'(disp);
        for (int i = 0; i < WAY; i++) begin
            pc[i]             = $urandom;
            pc_next[i]        = $urandom;
            br_pred_valid[i]  = 1'($urandom_range(0, 1));
            br_pred_taken[i]  = 1'($urandom_range(0, 1));
            br_pred_target[i] = $urandom;
            br_pred_index[i]  = HB'($urandom);
        end
        exp_pop = !emp && ((DEPTH - exp_q.size()) >= WAY) && !fl;
        #1;
        obs_pop = iq_pop;
        if (fl) begin
            exp_q.delete();
        end else begin
            repeat (disp) void'(exp_q.pop_front());
            if (exp_pop && resp) begin
                for (int i = 0; i < WAY; i++) begin
                    if (lv[i]) begin
                        u = ref_decode(ins[i], i, legal);
                        if (legal) exp_q.push_back(u);
                        else       exp_ill = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; iq_empty = 1'b0; iq_resp = 1'b1; iq_lane_valid = '1;
        iq_rdata = {addi_k(2), addi_k(1)}; disp_count = '0;
        pc = '0; pc_next = '0; br_pred_valid = '0; br_pred_taken = '0;
        br_pred_target = '0; br_pred_index = '0;
        #1;
        n_vec++; if (iq_pop !== 1'b0) begin n_err++; $display("FAIL reset_pop: got %b want 0", iq_pop); end
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (occupancy !== '0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_vec++; if (uop_valid !== '0) begin n_err++; $display("FAIL reset_valid: got %b want 0", uop_valid); end
        n_vec++; if (uop_out !== '0) begin n_err++; $display("FAIL reset_uop: got %h want 0", uop_out); end
        n_vec++; if (illegal_seen !== 1'b0) begin n_err++; $display("FAIL reset_ill: got %b want 0", illegal_seen); end
        rst = 1'b0;
        exp_q.delete();
        exp_ill = 1'b0;
    endtask

    task automatic test_decode_basic();
        // Lane order in the packed literal is {lane1, lane0}.
        drive(1'b0, 1'b0, 1'b1, 2'b11, {32'h1234_5137, 32'h0050_0093}, 0);
        n_vec++; if (obs_pop !== 1'b1) begin n_err++; $display("FAIL basic_pop: got %b want 1", obs_pop); end
        n_vec++; if (uop_valid !== 2'b11) begin n_err++; $display("FAIL basic_valid: got %b want 11", uop_valid); end
        n_vec++; if (occupancy !== 4'd2) begin n_err++; $display("FAIL basic_occ: got %0d want 2", occupancy); end
        n_vec++; if (uop_out[0].imms !== 32'd5) begin n_err++; $display("FAIL basic_imm0: got %h want 5", uop_out[0].imms); end
        n_vec++; if (uop_out[0].fu_idx !== FU_ALU) begin n_err++; $display("FAIL basic_fu0: got %0d want %0d", uop_out[0].fu_idx, FU_ALU); end
        n_vec++; if (uop_out[1].imms !== 32'h1234_5000) begin n_err++; $display("FAIL basic_imm1: got %h want 12345000", uop_out[1].imms); end
        n_vec++; if (uop_out[1].fu_idx !== 4'(FU_LUI_B + 1)) begin n_err++; $display("FAIL basic_fu1: got %0d want %0d", uop_out[1].fu_idx, FU_LUI_B + 1); end
        drive(1'b0, 1'b1, 1'b1, 2'b00, '0, 1);
        n_vec++; if (uop_out[0].fu_idx !== FU_LUI_B) begin n_err++; $display("FAIL shift_fu0: got %0d want %0d", uop_out[0].fu_idx, FU_LUI_B); end
        n_vec++; if (uop_out[0].imms !== 32'h1234_5000) begin n_err++; $display("FAIL shift_imm0: got %h want 12345000", uop_out[0].imms); end
        n_vec++; if (occupancy !== 4'd1) begin n_err++; $display("FAIL shift_occ: got %0d want 1", occupancy); end
        n_vec++; if (uop_valid !== 2'b01) begin n_err++; $display("FAIL shift_valid: got %b want 01", uop_valid); end
        drive(1'b0, 1'b1, 1'b1, 2'b00, '0, 1);
        n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL drain_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_illegal();
        drive(1'b0, 1'b0, 1'b1, 2'b01, {32'hFFFF_FFFF, 32'h0020_81B3}, 0);
        n_vec++; if (occupancy !== 4'd1) begin n_err++; $display("FAIL masked_occ: got %0d want 1", occupancy); end
        n_vec++; if (illegal_seen !== 1'b0) begin n_err++; $display("FAIL masked_ill: got %b want 0", illegal_seen); end
        n_vec++; if (uop_out[0].rd !== 5'd3) begin n_err++; $display("FAIL masked_rd: got %0d want 3", uop_out[0].rd); end
        drive(1'b0, 1'b1, 1'b1, 2'b00, '0, 1);
        drive(1'b0, 1'b0, 1'b1, 2'b11, {32'h0020_81B3, 32'hFFFF_FFFF}, 0);
        n_vec++; if (occupancy !== 4'd1) begin n_err++; $display("FAIL ill_occ: got %0d want 1", occupancy); end
        n_vec++; if (uop_valid !== 2'b01) begin n_err++; $display("FAIL ill_valid: got %b want 01", uop_valid); end
        n_vec++; if (uop_out[0].rs2_s !== 5'd2) begin n_err++; $display("FAIL ill_rs2: got %0d want 2", uop_out[0].rs2_s); end
        n_vec++; if (uop_out[0].rs1_s !== 5'd1) begin n_err++; $display("FAIL ill_rs1: got %0d want 1", uop_out[0].rs1_s); end
        n_vec++; if (uop_out[0].fu_idx !== FU_ALU) begin n_err++; $display("FAIL ill_fu: got %0d want %0d", uop_out[0].fu_idx, FU_ALU); end
        n_vec++; if (illegal_seen !== 1'b1) begin n_err++; $display("FAIL ill_flag: got %b want 1", illegal_seen); end
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b0, 1'b1, 2'b11, {addi_k(2), addi_k(1)}, 0);
        n_vec++; if (occupancy !== 4'd3) begin n_err++; $display("FAIL preflush_occ: got %0d want 3", occupancy); end
        drive(1'b1, 1'b0, 1'b1, 2'b11, {addi_k(4), addi_k(3)}, 2);
        n_vec++; if (obs_pop !== 1'b0) begin n_err++; $display("FAIL flush_pop: got %b want 0", obs_pop); end
        n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        n_vec++; if (uop_valid !== 2'b00) begin n_err++; $display("FAIL flush_valid: got %b want 00", uop_valid); end
        n_vec++; if (uop_out !== '0) begin n_err++; $display("FAIL flush_uop: got %h want 0", uop_out); end
        n_vec++; if (illegal_seen !== 1'b1) begin n_err++; $display("FAIL flush_ill: got %b want 1", illegal_seen); end
    endtask

    task automatic test_store();
        drive(1'b0, 1'b0, 1'b1, 2'b01, {32'h0, 32'hFE53_2E23}, 0);
        n_vec++; if (uop_out[0].imms !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL st_imm: got %h want fffffffc", uop_out[0].imms); end
        n_vec++; if (uop_out[0].rs1_s !== 5'd6) begin n_err++; $display("FAIL st_rs1: got %0d want 6", uop_out[0].rs1_s); end
        n_vec++; if (uop_out[0].rs2_s !== 5'd5) begin n_err++; $display("FAIL st_rs2: got %0d want 5", uop_out[0].rs2_s); end
        n_vec++; if (uop_out[0].fu_idx !== FU_MEM_ST) begin n_err++; $display("FAIL st_fu: got %0d want %0d", uop_out[0].fu_idx, FU_MEM_ST); end
        n_vec++; if (uop_out[0].rd_valid !== 1'b0) begin n_err++; $display("FAIL st_rdv: got %b want 0", uop_out[0].rd_valid); end
        n_vec++; if (uop_out[0].id_valid !== 1'b1) begin n_err++; $display("FAIL st_idv: got %b want 1", uop_out[0].id_valid); end
        drive(1'b0, 1'b1, 1'b1, 2'b00, '0, 1);
    endtask

    task automatic test_full_wrap();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ill = 1'b0;
        for (int b = 0; b < 3; b++) drive(1'b0, 1'b0, 1'b1, 2'b11, {addi_k(2*b+2), addi_k(2*b+1)}, 0);
        drive(1'b0, 1'b0, 1'b1, 2'b01, {32'h0, addi_k(7)}, 0);
        n_vec++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL fill_occ: got %0d want 7", occupancy); end
        drive(1'b0, 1'b0, 1'b1, 2'b11, {addi_k(99), addi_k(98)}, 0);
        n_vec++; if (obs_pop !== 1'b0) begin n_err++; $display("FAIL nearfull_pop: got %b want 0", obs_pop); end
        drive(1'b0, 1'b0, 1'b1, 2'b11, {addi_k(99), addi_k(98)}, 1);
        n_vec++; if (obs_pop !== 1'b0) begin n_err++; $display("FAIL nocredit_pop: got %b want 0", obs_pop); end
        n_vec++; if (occupancy !== 4'd6) begin n_err++; $display("FAIL credit_occ: got %0d want 6", occupancy); end
        drive(1'b0, 1'b0, 1'b1, 2'b11, {addi_k(9), addi_k(8)}, 0);
        n_vec++; if (obs_pop !== 1'b1) begin n_err++; $display("FAIL reopen_pop: got %b want 1", obs_pop); end
        n_vec++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL full_occ: got %0d want 8", occupancy); end
        drive(1'b0, 1'b0, 1'b1, 2'b11, {addi_k(99), addi_k(98)}, 0);
        n_vec++; if (obs_pop !== 1'b0) begin n_err++; $display("FAIL full_pop: got %b want 0", obs_pop); end
        for (int j = 0; j < 4; j++) begin
            for (int s = 0; s < WAY; s++) begin
                n_vec++;
                if (uop_out[s].imms !== 32'(2 + 2*j + s)) begin
                    n_err++;
                    $display("FAIL wrap_order[%0d][%0d]: got %0d want %0d", j, s, uop_out[s].imms, 2 + 2*j + s);
                end
            end
            drive(1'b0, 1'b1, 1'b1, 2'b00, '0, 2);
        end
        n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL wrap_drain_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_random();
        logic [WAY-1:0][31:0] ins;
        logic [WAY-1:0] exp_v;
        logic [31:0] r;
        id_rename_nd_dispatch_t e;
        int lim;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < WAY; i++) begin
                r = $urandom;
                r[6:0] = op_tab[$urandom_range(0, 9)];
                ins[i] = r;
            end
            lim = (exp_q.size() < WAY) ? exp_q.size() : WAY;
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) != 0,
                  WAY'($urandom), ins, $urandom_range(0, lim));
            n_vec++; if (obs_pop !== exp_pop) begin n_err++; $display("FAIL rnd_pop @%0d: got %b want %b", c, obs_pop, exp_pop); end
            n_vec++; if (occupancy !== OCC_W'(exp_q.size())) begin n_err++; $display("FAIL rnd_occ @%0d: got %0d want %0d", c, occupancy, exp_q.size()); end
            n_vec++; if (illegal_seen !== exp_ill) begin n_err++; $display("FAIL rnd_ill @%0d: got %b want %b", c, illegal_seen, exp_ill); end
            for (int s = 0; s < WAY; s++) exp_v[s] = (s < exp_q.size());
            n_vec++; if (uop_valid !== exp_v) begin n_err++; $display("FAIL rnd_valid @%0d: got %b want %b", c, uop_valid, exp_v); end
            for (int s = 0; s < WAY; s++) begin
                e = '0;
                if (s < exp_q.size()) begin
                    e = exp_q[s];
                    if (e.opcode == 7'h37) e.fu_idx = 4'(FU_LUI_B + s);
                end
                n_vec++;
                if (uop_out[s] !== e) begin
                    n_err++;
                    $display("FAIL rnd_uop[%0d] @%0d: got %h want %h", s, c, uop_out[s], e);
                end
            end
        end
    endtask

    initial begin
        op_tab[0] = 7'h37; op_tab[1] = 7'h17; op_tab[2] = 7'h6F; op_tab[3] = 7'h67; op_tab[4] = 7'h63;
        op_tab[5] = 7'h03; op_tab[6] = 7'h23; op_tab[7] = 7'h13; op_tab[8] = 7'h33; op_tab[9] = 7'h0F;
        exp_ill = 1'b0;
        test_reset();
        test_decode_basic();
        test_illegal();
        test_flush();
        test_store();
        test_full_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/id_decode_buffer.md
# id_decode_buffer

Parametrised WAY-wide decode stage with a registered circular buffer of decoded uops, sitting between the instruction queue and rename/dispatch. Each instruction-queue pop decodes up to WAY instructions. Illegal or masked lanes are compacted out, and the surviving uops are written in program order. Rename/dispatch consumes 0..WAY of the oldest uops per cycle, so a partial dispatch no longer stalls the whole bundle.

## Interface
- WAY, 2, decode/dispatch width (1..4)
- DEPTH, 8, buffer entries; power of two, DEPTH >= 2*WAY
- HISTORY_BITS, 8, width of the branch-predictor index carried per uop
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  pipeline redirect; empties the buffer
- iq_empty  in  1  instruction queue has no bundle
- iq_pop  out  1  pop one WAY bundle from the instruction queue
- iq_resp  in  1  same-cycle read-data valid for the popped bundle
- iq_rdata  in  32 x WAY  instruction words, lane 0 oldest
- iq_lane_valid  in  WAY  per-lane valid mask for the fetched bundle (covers partial bundles after a taken branch)
- pc, pc_next  in  32 x WAY  per-lane PC and predicted next PC
- br_pred_valid, br_pred_taken  in  1 x WAY  predictor outputs
- br_pred_target  in  32 x WAY  predictor target
- br_pred_index  in  HISTORY_BITS x WAY  predictor index
- uop_out  out  id_rename_nd_dispatch_t x WAY  oldest WAY buffered uops, slot 0 oldest
- uop_valid  out  WAY  slot i holds a valid uop (always a prefix mask)
- disp_count  in  clog2(WAY+1)  number of slots consumed this cycle; must not exceed popcount(uop_valid)
- occupancy  out  clog2(DEPTH+1)  current entry count
- illegal_seen  out  1  sticky flag: a valid lane decoded to an unsupported opcode; cleared by rst only

## Operation
- Decode is per lane and combinational, with team-standard field mapping:
  - imm types: I, S, B, U, J.
  - rs2_s is zeroed unless the opcode is op_reg, op_store or op_br.
  - funct7 is forwarded for op_reg, and for op_imm only when funct3=5.
  - fu_idx assignment:
    - op_auipc and op_imm -> ALU
    - op_jal, op_jalr and op_br -> BRANCH
    - op_load -> MEM_LD; op_store -> MEM_ST
    - op_reg with funct7[0]=1 -> MUL when funct3[2]=0, DIV when funct3[2]=1
    - all other op_reg -> ALU
  - rd_valid, rs1_s_valid, rs2_s_valid, jump_valid, br_valid, mem_stage_valid and imm_flag are set per opcode class.
  - id_valid=1 for every written uop.
- A lane is kept when iq_lane_valid[i]=1 and its opcode is one of the 9 supported.
  - A lane with iq_lane_valid[i]=1 and an unsupported opcode is dropped and sets illegal_seen.
- Kept lanes are compacted in lane order and written at tail, tail+1, … (mod DEPTH).
- fu_idx for op_lui is not stored fixed. uop_out[s].fu_idx = LUI_B + s, recomputed from the output slot index s.
- iq_pop = !iq_empty && (DEPTH - occupancy) >= WAY && !flush && !rst.
  - Free space uses the registered occupancy only; the same cycle's disp_count is not credited.
- Write happens on the clock edge when iq_pop && iq_resp.
- Read side: uop_out[s] = entry[(head+s) mod DEPTH] and uop_valid[s] = (s < occupancy). Slots with uop_valid[s]=0 drive '0.
- Pointer and count update on each edge:
  - head += disp_count
  - tail += number kept
  - occupancy += kept - disp_count
  - Simultaneous write and consume are both applied in the same cycle.

## Timing
- Reset, and any cycle with flush=1, produces on the next edge:
  - head=tail=0, occupancy=0, all uop_valid=0, uop_out='0
  - iq_pop=0 during that cycle; same-cycle write and disp_count are ignored
- illegal_seen resets to 0; flush does not clear it.
- Latency: an instruction popped in cycle N is visible on uop_out in cycle N+1 at the earliest.
- Throughput: WAY uops per cycle sustained when occupancy <= DEPTH-WAY and dispatch consumes WAY per cycle.
- Pointers wrap mod DEPTH. Full is occupancy==DEPTH and empty is occupancy==0; no aliasing.
- If disp_count exceeds popcount(uop_valid), the behaviour is an assertion failure in simulation.
- iq_resp=0 while iq_pop=1 means no write; the pop is still counted by the queue.

## Test plan
- Reset then a WAY=2 bundle {addi x1,x0,5 ; lui x2,0x12345}, both lanes valid, disp_count=0:
  - cycle+1: uop_valid=2'b11, occupancy=2
  - slot0: imms=5, fu_idx=ALU
  - slot1: imms=0x12345000, fu_idx=LUI_B+1
- Same bundle with disp_count=1 in the next cycle:
  - lui moves to slot0 with fu_idx=LUI_B+0
  - occupancy=1
- Bundle {0xFFFFFFFF ; add x3,x1,x2}:
  - only the add is written, into slot0 with rs2_s=2
  - illegal_seen=1
  - iq_lane_valid=2'b01 with a valid lane1 drops lane1 silently and leaves illegal_seen unchanged
- Fill to occupancy=7 with DEPTH=8, WAY=2:
  - iq_pop=0 even with iq_empty=0
  - after disp_count=1, iq_pop=1 the next cycle
  - tail wraps from 7 to 1 with correct ordering
- flush in the same cycle as a write and disp_count=2:
  - next cycle occupancy=0 and uop_valid=0
  - illegal_seen is retained
- Store sw x5,-4(x6):
  - imms=0xFFFFFFFC, rs1_s=6, rs2_s=5, fu_idx=MEM_ST
  - rd_valid=0, id_valid=1
